// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: sizing, record type and helpers shared by the
// commit trace queue and its pending-slot matcher.
package commit_trace_pkg;
   localparam int COMMITS = 2;
   localparam int DEPTH   = 16;
   localparam int XLEN    = 64;
   localparam int TIMEOUT = 1024;
   localparam int PTR_W   = $clog2(DEPTH);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     insn;
      logic            wen;
      logic [4:0]      rd;
      logic [XLEN-1:0] wdata;
   } commit_rec_t;

   function automatic cnt_t popcount(input logic [COMMITS-1:0] v);
      cnt_t n;
      n = '0;
      for (int i = 0; i < COMMITS; i++) begin
         n = n + cnt_t'(v[i]);
      end
      return n;
   endfunction
endpackage

// File: rtl/commit_trace_match.sv
// commit_trace_match: finds the oldest pending slot, counted from head,
// whose destination register equals the late writeback register.
module commit_trace_match
   import commit_trace_pkg::*;
(
   input  logic [DEPTH-1:0]      i_pend,
   input  logic [DEPTH-1:0][4:0] i_rd,
   input  ptr_t                  i_head,
   input  logic [4:0]            i_wb_rd,
   output logic                  o_hit,
   output ptr_t                  o_slot
);
   always_comb begin
      o_hit  = 1'b0;
      o_slot = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (!o_hit && i_pend[i_head + ptr_t'(k)]
             && (i_rd[i_head + ptr_t'(k)] == i_wb_rd)) begin
            o_hit  = 1'b1;
            o_slot = i_head + ptr_t'(k);
         end
      end
   end
endmodule

// File: rtl/commit_trace_queue.sv
// commit_trace_queue: in-order retire record buffer with late rd fill-in.
// Define COMMIT_TRACE_WATCHDOG_EN to add the head-pending watchdog (wb_timeout).
module commit_trace_queue
   import commit_trace_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic [COMMITS-1:0]      ret_valid,
   input  logic [COMMITS*XLEN-1:0] ret_pc,
   input  logic [COMMITS*32-1:0]   ret_insn,
   input  logic [COMMITS-1:0]      ret_wen,
   input  logic [COMMITS-1:0]      ret_late,
   input  logic [COMMITS*5-1:0]    ret_rd,
   input  logic [COMMITS*XLEN-1:0] ret_wdata,
   input  logic                    wb_valid,
   input  logic [4:0]              wb_rd,
   input  logic [XLEN-1:0]         wb_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_pc,
   output logic [31:0]             out_insn,
   output logic                    out_wen,
   output logic [4:0]              out_rd,
   output logic [XLEN-1:0]         out_wdata,
   output logic [PTR_W:0]          occupancy,
   output logic                    overflow,
`ifdef COMMIT_TRACE_WATCHDOG_EN
   output logic                    wb_timeout,
`endif
   output logic                    orphan_wb
);
   commit_rec_t      r_mem [DEPTH];
   logic [DEPTH-1:0] r_pend;
   ptr_t             r_head;
   ptr_t             r_tail;
   cnt_t             r_occ;
   logic             r_ovf;
   logic             r_orph;

   commit_rec_t           w_head_rec;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_hit;
   logic                  w_fill;
   ptr_t                  w_slot;
   cnt_t                  w_cnt;
   cnt_t                  w_free;
   ptr_t                  w_off [COMMITS];
   logic [DEPTH-1:0][4:0] w_rds;

   assign w_head_rec = r_mem[r_head];
   assign out_valid  = (r_occ != '0) && !r_pend[r_head];
   assign w_pop      = out_valid & out_ready;
   assign w_cnt      = popcount(ret_valid);
   assign w_free     = cnt_t'(DEPTH) - r_occ + cnt_t'(w_pop);
   assign w_drop     = w_cnt > w_free;
   assign w_push     = (w_cnt != '0) && !w_drop;
   assign w_fill     = wb_valid & w_hit;

   // Slot offset of each lane after squeezing out the idle lanes.
   always_comb begin
      w_off[0] = '0;
      for (int l = 1; l < COMMITS; l++) begin
         w_off[l] = w_off[l-1] + ptr_t'(ret_valid[l-1]);
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_rds
      assign w_rds[i] = r_mem[i].rd;
   end

   commit_trace_match u_match (
      .i_pend  (r_pend),
      .i_rd    (w_rds),
      .i_head  (r_head),
      .i_wb_rd (wb_rd),
      .o_hit   (w_hit),
      .o_slot  (w_slot)
   );

   always_ff @(posedge clock) begin
      if (w_fill) r_mem[w_slot].wdata <= wb_data;
      for (int l = 0; l < COMMITS; l++) begin
         if (w_push && ret_valid[l]) begin
            r_mem[r_tail + w_off[l]] <= '{
               pc:    ret_pc[l*XLEN +: XLEN],
               insn:  ret_insn[l*32 +: 32],
               wen:   ret_wen[l],
               rd:    ret_rd[l*5 +: 5],
               wdata: ret_wdata[l*XLEN +: XLEN]};
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
         r_pend <= '0;
         r_ovf  <= 1'b0;
         r_orph <= 1'b0;
      end else begin
         if (w_fill) r_pend[w_slot] <= 1'b0;
         for (int l = 0; l < COMMITS; l++) begin
            if (w_push && ret_valid[l])
               r_pend[r_tail + w_off[l]] <= ret_wen[l] & ret_late[l];
         end
         if (w_pop) r_head <= r_head + ptr_t'(1);
         if (w_push) r_tail <= r_tail + w_cnt[PTR_W-1:0];
         r_occ <= r_occ + (w_push ? w_cnt : '0) - cnt_t'(w_pop);
         if (w_drop) r_ovf <= 1'b1;
         if (wb_valid && !w_hit) r_orph <= 1'b1;
      end
   end

`ifdef COMMIT_TRACE_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] r_wd;
   logic            r_wdto;
   logic            w_stall;

   assign w_stall    = (r_occ != '0) && r_pend[r_head];
   assign wb_timeout = r_wdto;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wd   <= '0;
         r_wdto <= 1'b0;
      end else if (!w_stall) begin
         r_wd <= '0;
      end else if (r_wd != WD_W'(TIMEOUT)) begin
         r_wd <= r_wd + WD_W'(1);
         if (r_wd == WD_W'(TIMEOUT - 1) && !r_wdto) begin
            r_wdto <= 1'b1;
`ifndef SYNTHESIS
            $error("commit_trace_queue: wb timeout pc=%h rd=%0d",
                   w_head_rec.pc, w_head_rec.rd);
`endif
         end
      end
   end
`endif

   assign out_pc    = out_valid ? w_head_rec.pc   : '0;
   assign out_insn  = out_valid ? w_head_rec.insn : '0;
   assign out_wen   = out_valid ? w_head_rec.wen  : 1'b0;
   assign out_rd    = out_valid ? w_head_rec.rd   : '0;
   assign out_wdata = (out_valid && w_head_rec.rd != 5'd0) ? w_head_rec.wdata : '0;
   assign occupancy = r_occ;
   assign overflow  = r_ovf;
   assign orphan_wb = r_orph;
endmodule

// File: doc/commit_trace_queue.md
Name: commit_trace_queue

Overview:
- Sits between the core's retire ports and the co-simulation checker.
- Captures up to COMMITS retire records per cycle in program order.
- Fills in register writeback data that arrives late (loads, divides) and presents completed records one at a time over a valid/ready port.
- The checker calls cosim_commit/cosim_judge only on records whose data is final.

Parameters:
COMMITS, 2, retire lanes per cycle; lane 0 is oldest
DEPTH, 16, record slots; power of two, >= 2*COMMITS
XLEN, 64, pc/wdata width
TIMEOUT, 1024, head-pending watchdog limit in cycles (used only with the optional feature)

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-low reset
ret_valid  in  COMMITS  lane retires this cycle
ret_pc  in  COMMITS*XLEN  per-lane pc
ret_insn  in  COMMITS*32  per-lane instruction
ret_wen  in  COMMITS  lane writes an integer rd
ret_late  in  COMMITS  rd data arrives later via wb_*
ret_rd  in  COMMITS*5  destination register
ret_wdata  in  COMMITS*XLEN  rd data; ignored when ret_late=1
wb_valid  in  1  late writeback strobe
wb_rd  in  5  late writeback register
wb_data  in  XLEN  late writeback data
out_valid  out  1  head record complete
out_ready  in  1  checker accepts
out_pc  out  XLEN  head pc
out_insn  out  32  head insn
out_wen  out  1  head writes rd
out_rd  out  5  head rd
out_wdata  out  XLEN  head rd data
occupancy  out  log2(DEPTH)+1  slots in use
overflow  out  1  sticky: retire dropped for lack of space
orphan_wb  out  1  sticky: wb matched no pending slot

Behaviour:
- Reset (async, active-low):
  - head, tail and occupancy cleared to 0; all pending bits cleared.
  - overflow=0, orphan_wb=0, out_valid=0.
  - Data outputs are 0; record contents are not reset.
- Push:
  - Valid lanes are compacted in lane order and written at tail.
  - Each pushed slot gets pending = ret_wen & ret_late.
  - tail advances by popcount(ret_valid), modulo DEPTH.
- Space check: free = DEPTH - occupancy + (pop this cycle).
  - If popcount > free, the whole group is dropped, overflow is set, and tail is unchanged. No partial push.
- Pop:
  - out_valid = occupancy != 0 and head not pending. It is combinational from state, so output latency is 1 cycle after push.
  - Pop happens when out_valid & out_ready; head advances by 1.
  - The out_* fields may change only after a pop.
- Late writeback:
  - The oldest pending slot (head-relative) with rd == wb_rd takes wb_data; its pending bit clears at the clock edge.
  - Slots pushed in the same cycle are not candidates.
  - No match sets orphan_wb; the data is dropped.
  - The core guarantees at most one outstanding late write per rd; the queue does not check this.
- Simultaneous events:
  - A wb clearing head's pending bit makes head poppable on the next cycle, not the same cycle.
  - Push, pop and wb may all occur in one cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full is occupancy == DEPTH.
- rd == 0 with wen=1 is recorded as-is; out_wdata is forced to 0 for rd 0.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: COMMIT_TRACE_WATCHDOG_EN.
- With the macro:
  - A counter increments each cycle that occupancy != 0 and head is pending; it resets to 0 otherwise.
  - When it reaches TIMEOUT, sticky output wb_timeout is asserted and $error prints head pc and rd once.
- Without the macro: no counter, the wb_timeout port is absent, and TIMEOUT is unused.

Decomposition:
- commit_trace_pkg holds:
  - typedef commit_rec_t {pc, insn, wen, rd, wdata}
  - localparam PTR_W = $clog2(DEPTH)
  - function popcount
- Sub-module commit_trace_match: DEPTH-wide oldest-first priority search. Inputs are the pending vector, rd array, head and wb_rd; outputs are hit and slot index. Purely combinational, instantiated once.

Test Plan:
1. Two-lane retire, pc 0x80000000/0x80000004, both non-late, out_ready=1 -> records emerge on consecutive cycles in lane order; occupancy returns to 0.
2. Lane 0 load rd=5 late, lane 1 addi rd=6 wdata=0x7 -> out_valid stays 0; wb rd=5 data=0xdead3 after 10 cycles -> next cycle head emits 0xdead3, then the rd=6 record.
3. Two pending slots both rd=5 -> first wb fills the older slot only; second wb fills the younger slot.
4. Fill to 16 with out_ready=0, then retire 2 -> overflow=1, occupancy stays 16; at occupancy 15 with out_ready=1 and 2 retiring, both are accepted.
5. wb rd=9 with no pending slot -> orphan_wb=1; other records unaffected.
6. Assert reset mid-stream with occupancy 7 -> outputs zero immediately (asynchronous); after release, a new retire appears as the first record.
